div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//   Iterative RV32M divider (DIV/DIVU/REM/REMU): the multi-cycle counterpart to the combinational ALU in execute.
//   Execute issues one operation with a start pulse and holds the pipeline while busy=1.
//   The unit returns one 32-bit result with a 1-cycle done pulse.
//   Radix-2 restoring algorithm on magnitudes, with sign fix-up in a final cycle.
// PARAMETERS
//   UNROLL  1  quotient bits resolved per cycle; legal 1,2,4,8; normal latency = 32/UNROLL + 1 cycles
// PORTS
//   clk              input   1   clock; all state on rising edge
//   reset            input   1   synchronous, active-high
//   start            input   1   issue request; sampled only in IDLE
//   kill             input   1   pipeline flush; aborts any operation
//   function_select  input   2   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   input_a          input   32  dividend (rs1)
//   input_b          input   32  divisor (rs2)
//   busy             output  1   high whenever state != IDLE
//   done             output  1   1-cycle pulse; result valid in the same cycle
//   result           output  32  registered; holds until the next done
// BEHAVIOUR
//   Interface: one clock (clk); reset is synchronous and active-high (reset).
//   Reset: state=IDLE, busy=0, done=0, result=0, counter=0.
//   Priority order: reset > kill > start.
//   States:
//   - IDLE: on start=1 and kill=0, latch operands, op, signs and |a|,|b|.
//     Divisor==0 or signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) -> FINISH with preset result.
//     Otherwise -> DIVIDE, counter=0.
//   - DIVIDE: each cycle shift UNROLL dividend bits into the partial remainder.
//     Per bit: trial-subtract the divisor; set the quotient bit when the 33-bit difference is non-negative.
//     counter+=UNROLL; leave after 32/UNROLL cycles -> FINISH.
//   - FINISH: done=1 and result registered this cycle, then -> IDLE.
//     Quotient negated iff signed op and sign(a)!=sign(b); remainder negated iff signed op and a<0.
//   Latency: start in cycle 0 -> done in cycle 32/UNROLL+1 (33 for UNROLL=1). Special cases -> done in cycle 1.
//   Special results:
//   - divide-by-zero: quotient=0xFFFFFFFF (DIV and DIVU), remainder=input_a.
//   - signed overflow: quotient=0x80000000, remainder=0.
//   Operand independence: operands are captured at start; input changes while busy have no effect.
//   start while busy is ignored (no queueing).
//   kill: in any state -> IDLE next cycle, done stays 0, result unchanged.
//     kill together with start in IDLE -> start ignored.
//     kill in FINISH -> done of that cycle is suppressed and result is not updated.
//   Back-to-back: start may be asserted in the cycle after done (state is IDLE again).
//   Width: remainder datapath is 33 bits; magnitude of 0x80000000 is 0x80000000 unsigned (no overflow).
// STRUCTURE
//   Shared package (core defs): DIV_DIV/DIV_DIVU/DIV_REM/DIV_REMU encodings and the div state enum.
//   Sub-module div_step: combinational single restoring step.
//   - Inputs: {rem[32:0], dividend bit, divisor[31:0]}.
//   - Outputs: {next rem, quotient bit}.
//   - A generate loop chains UNROLL instances.
//   Top level holds the FSM, counter, operand/sign registers and the fix-up logic.
// TESTING
//   1. DIVU 100/7 with UNROLL=1: busy for cycles 1..32, done pulse in cycle 33 only, result=14. REMU same operands -> 2.
//   2. Signed DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIV 7/-2 -> -3. REM 7/-2 -> 1.
//   3. Special cases, each done in cycle 1 after start:
//      DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0.
//   4. kill at cycle 10 of DIVU 1000/3: busy=0 next cycle, no done, result keeps the previous value.
//      A new start then completes correctly.
//   5. start held high for 40 cycles with changing input_a: exactly one done at cycle 33, using the first-captured operands.
//      Re-issue in cycle 34 is accepted.
//   6. reset asserted mid-DIVIDE: next cycle busy=0, done=0, result=0.
//      Repeat tests 1-3 with UNROLL=4: done at cycle 9, same results.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative RV32M divider: operation encodings,
// FSM state type and the operand magnitude helper.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_DIVIDE,
    DIV_FINISH
  } div_state_e;

  // 0x80000000 maps to itself, which is exactly its unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Issue/result handshake between execute (master) and the divider (slave).
interface div_unit_if;
  logic        start;
  logic        kill;
  logic [1:0]  function_select;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, kill, function_select, input_a, input_b,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, function_select, input_a, input_b,
    output busy, done, result
  );
endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module div_unit_step (
  input  logic [32:0] rem,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [32:0] next_rem,
  output logic        q_bit
);
  logic [33:0] shifted;
  logic [33:0] diff;

  assign shifted  = {rem, dividend_bit};
  assign diff     = shifted - {2'b00, divisor};
  assign q_bit    = ~diff[33];
  assign next_rem = q_bit ? diff[32:0] : shifted[32:0];
endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): magnitude restoring division,
// UNROLL quotient bits per cycle, sign fix-up in a final FINISH cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input logic       clk,
  input logic       reset,
  div_unit_if.slave bus
);
  localparam logic [5:0] LAST_COUNT = 6'(32 - UNROLL);

  div_state_e  state_q, state_d;
  logic [5:0]  counter_q;
  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] divisor_q;
  logic [31:0] result_q;
  logic [31:0] fix_val;
  logic        is_rem_q, neg_quo_q, neg_rem_q, special_q;
  logic        done_w, op_signed, div_by_zero, overflow, accept;

  logic [32:0]       rem_chain [UNROLL+1];
  logic [UNROLL-1:0] q_bits;

  assign op_signed   = ~bus.function_select[0];
  assign div_by_zero = (bus.input_b == 32'd0);
  assign overflow    = op_signed && (bus.input_a == 32'h8000_0000) && (bus.input_b == 32'hFFFF_FFFF);
  assign accept      = (state_q == DIV_IDLE) && bus.start && !bus.kill;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= DIV_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    done_w  = 1'b0;
    case (state_q)
      DIV_IDLE:   if (bus.start) state_d = (div_by_zero || overflow) ? DIV_FINISH : DIV_DIVIDE;
      DIV_DIVIDE: if (counter_q == LAST_COUNT) state_d = DIV_FINISH;
      DIV_FINISH: begin
        done_w  = 1'b1;
        state_d = DIV_IDLE;
      end
      default:    state_d = DIV_IDLE;
    endcase
    // A flush overrides everything, including the done pulse of FINISH.
    if (bus.kill) begin
      state_d = DIV_IDLE;
      done_w  = 1'b0;
    end
  end

  assign rem_chain[0] = rem_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    div_unit_step u_step (
      .rem          (rem_chain[i]),
      .dividend_bit (quo_q[31-i]),
      .divisor      (divisor_q),
      .next_rem     (rem_chain[i+1]),
      .q_bit        (q_bits[UNROLL-1-i])
    );
  end

  // quo_q starts as |a| and fills with quotient bits as the dividend shifts out.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
    end else begin
      if (accept) begin
        divisor_q <= magnitude(bus.input_b, op_signed);
        is_rem_q  <= bus.function_select[1];
        neg_quo_q <= op_signed && (bus.input_a[31] ^ bus.input_b[31]);
        neg_rem_q <= op_signed && bus.input_a[31];
        special_q <= div_by_zero || overflow;
        counter_q <= '0;
        if (div_by_zero) begin
          quo_q <= 32'hFFFF_FFFF;
          rem_q <= {1'b0, bus.input_a};
        end else if (overflow) begin
          quo_q <= 32'h8000_0000;
          rem_q <= '0;
        end else begin
          quo_q <= magnitude(bus.input_a, op_signed);
          rem_q <= '0;
        end
      end else if (state_q == DIV_DIVIDE) begin
        rem_q     <= rem_chain[UNROLL];
        quo_q     <= {quo_q[31-UNROLL:0], q_bits};
        counter_q <= counter_q + 6'(UNROLL);
      end
      if (done_w) result_q <= fix_val;
    end
  end

  // Preset special-case results bypass the sign fix-up.
  always_comb begin
    fix_val = is_rem_q ? rem_q[31:0] : quo_q;
    if (!special_q) begin
      if (is_rem_q && neg_rem_q)       fix_val = -rem_q[31:0];
      else if (!is_rem_q && neg_quo_q) fix_val = -quo_q;
    end
  end

  assign bus.busy   = (state_q != DIV_IDLE);
  assign bus.done   = done_w;
  assign bus.result = done_w ? fix_val : result_q;
endmodule
